// File: rtl/imem_fetch_resp.sv
// -----------------------------------------------------------------------------
// imem_fetch_resp
//
// Instruction-memory responder for the fetch stage. The PC unit presents a byte
// address together with Rd. The block accepts one fetch at a time and holds the
// PC off with Stall for a programmable latency. It then returns the instruction
// word with a one-cycle Done pulse. Flush aborts the fetch in flight (branch or
// jump redirect). A separate write port preloads the program image.
//
// Parameters:
//   LATENCY    cycles from acceptance to Done (legal 1..15)
//   DEPTH_LOG2 log2 of the number of 16-bit words; word index = Addr[DEPTH_LOG2:1]
//   NOP_WORD   word returned on a misaligned fetch
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset
//   Addr    in   [15:0] byte address of the requested instruction
//   Rd      in   fetch request
//   Flush   in   abort the in-flight fetch
//   WrEn    in   preload write enable
//   WrAddr  in   [15:0] preload byte address (bit 0 ignored)
//   WrData  in   [15:0] preload data
//   DataOut out  [15:0] instruction word, valid only while Done=1
//   Done    out  one-cycle response pulse
//   Stall   out  fetch in flight; the PC must hold
//   Err     out  qualifies Done: the fetch was misaligned
// -----------------------------------------------------------------------------
module imem_fetch_resp #(
    parameter int          LATENCY    = 2,
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [15:0] NOP_WORD   = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic        Rd,
    input  logic        Flush,
    input  logic        WrEn,
    input  logic [15:0] WrAddr,
    input  logic [15:0] WrData,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        Err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // BUSY lasts LATENCY-1 cycles, so the countdown starts at LATENCY-2.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    logic [15:0]           mem_r [0:DEPTH-1];

    state_t                state_r, state_s;
    logic [3:0]            cnt_r, cnt_s;
    logic [15:0]           cap_data_r, cap_data_s;
    logic                  cap_err_r, cap_err_s;
    logic [15:0]           data_r, data_s;
    logic                  done_r, done_s;
    logic                  stall_r, stall_s;
    logic                  err_r, err_s;

    logic [DEPTH_LOG2-1:0] rd_idx_s;
    logic [DEPTH_LOG2-1:0] wr_idx_s;
    logic [15:0]           fetch_word_s;
    logic                  fetch_err_s;
    logic                  accept_s;
    logic                  unused_addr_bits_s;

    // Upper address bits beyond the array simply wrap; they are not an error.
    assign rd_idx_s           = Addr[DEPTH_LOG2:1];
    assign wr_idx_s           = WrAddr[DEPTH_LOG2:1];
    assign unused_addr_bits_s = ^{Addr[15:DEPTH_LOG2+1], WrAddr[15:DEPTH_LOG2+1], WrAddr[0]};

    // The array is read before this edge's write lands, so a same-edge write
    // to the fetched word is not observed by that fetch.
    assign fetch_err_s  = Addr[0];
    assign fetch_word_s = Addr[0] ? NOP_WORD : mem_r[rd_idx_s];

    // Program image storage; intentionally not reset.
    always_ff @(posedge clk) begin
        if (WrEn) begin
            mem_r[wr_idx_s] <= WrData;
        end
    end

    // Acceptance: IDLE/RESP take a new fetch; BUSY only takes one when a
    // redirect (Flush) aborts the current fetch on the same edge.
    always_comb begin
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: accept_s = Rd;
            ST_RESP: accept_s = Rd;
            ST_BUSY: accept_s = Rd & Flush;
            default: accept_s = 1'b0;
        endcase
    end

    // Next-state and next-output logic; all outputs are registered from here.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        cap_data_s = cap_data_r;
        cap_err_s  = cap_err_r;
        data_s     = 16'h0000;
        done_s     = 1'b0;
        stall_s    = 1'b0;
        err_s      = 1'b0;

        if (accept_s) begin
            cap_data_s = fetch_word_s;
            cap_err_s  = fetch_err_s;
            if (LATENCY == 1) begin
                state_s = ST_RESP;
                done_s  = 1'b1;
                data_s  = fetch_word_s;
                err_s   = fetch_err_s;
            end else begin
                state_s = ST_BUSY;
                cnt_s   = CNT_LOAD;
                stall_s = 1'b1;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_BUSY: begin
                    if (Flush) begin
                        state_s = ST_IDLE;
                    end else if (cnt_r == 4'd0) begin
                        state_s = ST_RESP;
                        done_s  = 1'b1;
                        data_s  = cap_data_r;
                        err_s   = cap_err_r;
                    end else begin
                        cnt_s   = cnt_r - 4'd1;
                        stall_s = 1'b1;
                    end
                end
                ST_RESP: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter, captured fetch and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            cap_data_r <= 16'h0000;
            cap_err_r  <= 1'b0;
            data_r     <= 16'h0000;
            done_r     <= 1'b0;
            stall_r    <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            cap_data_r <= cap_data_s;
            cap_err_r  <= cap_err_s;
            data_r     <= data_s;
            done_r     <= done_s;
            stall_r    <= stall_s;
            err_r      <= err_s;
        end
    end

    assign DataOut = data_r;
    assign Done    = done_r;
    assign Stall   = stall_r;
    assign Err     = err_r;

endmodule

// File: tb/tb_imem_fetch_resp.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_resp
//
// Directed bench for imem_fetch_resp. Three instances (LATENCY 1, 2, 4) share
// the same inputs; each scenario checks the instance it targets. Outputs are
// packed as {13'b0, Done, Stall, Err, DataOut} for comparison.
// -----------------------------------------------------------------------------
module tb_imem_fetch_resp;

    logic        clk;
    logic        rst;
    logic [15:0] Addr;
    logic        Rd;
    logic        Flush;
    logic        WrEn;
    logic [15:0] WrAddr;
    logic [15:0] WrData;

    logic [15:0] q1, q2, q4;
    logic        d1, d2, d4;
    logic        s1, s2, s4;
    logic        e1, e2, e4;

    int n_cmp;
    int n_bad;

    imem_fetch_resp #(.LATENCY(1), .DEPTH_LOG2(8), .NOP_WORD(16'h0800)) u_l1 (
        .clk(clk), .rst(rst), .Addr(Addr), .Rd(Rd), .Flush(Flush),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .DataOut(q1), .Done(d1), .Stall(s1), .Err(e1)
    );

    imem_fetch_resp #(.LATENCY(2), .DEPTH_LOG2(8), .NOP_WORD(16'h0800)) u_l2 (
        .clk(clk), .rst(rst), .Addr(Addr), .Rd(Rd), .Flush(Flush),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .DataOut(q2), .Done(d2), .Stall(s2), .Err(e2)
    );

    imem_fetch_resp #(.LATENCY(4), .DEPTH_LOG2(8), .NOP_WORD(16'h0800)) u_l4 (
        .clk(clk), .rst(rst), .Addr(Addr), .Rd(Rd), .Flush(Flush),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .DataOut(q4), .Done(d4), .Stall(s4), .Err(e4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic d, input logic s,
                                         input logic e, input logic [15:0] q);
        return {13'd0, d, s, e, q};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        WrEn   = 1'b1;
        WrAddr = a;
        WrData = d;
        tick();
        WrEn   = 1'b0;
    endtask

    task automatic settle();
        Rd    = 1'b0;
        Flush = 1'b0;
        WrEn  = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b0;
        Addr   = 16'h0000;
        Rd     = 1'b0;
        Flush  = 1'b0;
        WrEn   = 1'b0;
        WrAddr = 16'h0000;
        WrData = 16'h0000;

        // Reset state
        #12;
        check_val("reset_l2", pack(d2, s2, e2, q2), pack(1'b0, 1'b0, 1'b0, 16'h0000));
        check_val("reset_l4", pack(d4, s4, e4, q4), pack(1'b0, 1'b0, 1'b0, 16'h0000));
        rst = 1'b1;
        tick();

        // Program image
        preload(16'h0010, 16'hC0DE);
        preload(16'h0000, 16'h0001);
        preload(16'h0002, 16'h0002);
        preload(16'h0004, 16'h0003);
        preload(16'h0020, 16'hAAAA);
        preload(16'h0040, 16'h4040);
        preload(16'h0012, 16'h1212);
        settle();

        // LATENCY=2 single fetch
        Addr = 16'h0010; Rd = 1'b1;
        tick();
        Rd = 1'b0;
        check_val("l2_stall", pack(d2, s2, e2, q2), pack(1'b0, 1'b1, 1'b0, 16'h0000));
        tick();
        check_val("l2_done", pack(d2, s2, e2, q2), pack(1'b1, 1'b0, 1'b0, 16'hC0DE));
        tick();
        check_val("l2_idle", pack(d2, s2, e2, q2), pack(1'b0, 1'b0, 1'b0, 16'h0000));
        settle();

        // LATENCY=1 back-to-back fetches
        Rd = 1'b1; Addr = 16'h0000;
        tick();
        check_val("l1_b2b_0", pack(d1, s1, e1, q1), pack(1'b1, 1'b0, 1'b0, 16'h0001));
        Addr = 16'h0002;
        tick();
        check_val("l1_b2b_1", pack(d1, s1, e1, q1), pack(1'b1, 1'b0, 1'b0, 16'h0002));
        Addr = 16'h0004;
        tick();
        check_val("l1_b2b_2", pack(d1, s1, e1, q1), pack(1'b1, 1'b0, 1'b0, 16'h0003));
        Rd = 1'b0;
        tick();
        check_val("l1_b2b_end", pack(d1, s1, e1, q1), pack(1'b0, 1'b0, 1'b0, 16'h0000));
        settle();

        // LATENCY=4 redirect on the 2nd BUSY cycle
        Addr = 16'h0020; Rd = 1'b1;
        tick();
        check_val("l4_busy1", pack(d4, s4, e4, q4), pack(1'b0, 1'b1, 1'b0, 16'h0000));
        tick();
        check_val("l4_busy2", pack(d4, s4, e4, q4), pack(1'b0, 1'b1, 1'b0, 16'h0000));
        Flush = 1'b1; Addr = 16'h0040;
        tick();
        Flush = 1'b0; Rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("l4_redirect_stall", pack(d4, s4, e4, q4), pack(1'b0, 1'b1, 1'b0, 16'h0000));
            tick();
        end
        check_val("l4_redirect_done", pack(d4, s4, e4, q4), pack(1'b1, 1'b0, 1'b0, 16'h4040));
        tick();
        check_val("l4_redirect_idle", pack(d4, s4, e4, q4), pack(1'b0, 1'b0, 1'b0, 16'h0000));
        settle();

        // Misaligned fetch returns the NOP word with Err
        Addr = 16'h0013; Rd = 1'b1;
        tick();
        Rd = 1'b0;
        check_val("mis_stall", pack(d2, s2, e2, q2), pack(1'b0, 1'b1, 1'b0, 16'h0000));
        tick();
        check_val("mis_done", pack(d2, s2, e2, q2), pack(1'b1, 1'b0, 1'b1, 16'h0800));
        tick();
        check_val("mis_idle", pack(d2, s2, e2, q2), pack(1'b0, 1'b0, 1'b0, 16'h0000));
        settle();

        // Wrapped address plus same-edge write to the same word
        Addr = 16'h0204; Rd = 1'b1;
        WrEn = 1'b1; WrAddr = 16'h0004; WrData = 16'hBEEF;
        tick();
        Rd = 1'b0; WrEn = 1'b0;
        tick();
        check_val("wrap_old_data", pack(d2, s2, e2, q2), pack(1'b1, 1'b0, 1'b0, 16'h0003));
        settle();
        Addr = 16'h0004; Rd = 1'b1;
        tick();
        Rd = 1'b0;
        tick();
        check_val("wrap_new_data", pack(d2, s2, e2, q2), pack(1'b1, 1'b0, 1'b0, 16'hBEEF));
        settle();

        // Flush with Rd=0 in BUSY drops the fetch
        Addr = 16'h0010; Rd = 1'b1;
        tick();
        Rd = 1'b0; Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check_val("flush_idle", pack(d4, s4, e4, q4), pack(1'b0, 1'b0, 1'b0, 16'h0000));
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("flush_no_done", {31'd0, d4}, 32'd0);
        end
        settle();

        // Asynchronous reset in the middle of BUSY
        Addr = 16'h0010; Rd = 1'b1;
        tick();
        Rd = 1'b0;
        check_val("arst_pre", pack(d4, s4, e4, q4), pack(1'b0, 1'b1, 1'b0, 16'h0000));
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_l4", pack(d4, s4, e4, q4), pack(1'b0, 1'b0, 1'b0, 16'h0000));
        check_val("arst_l2", pack(d2, s2, e2, q2), pack(1'b0, 1'b0, 1'b0, 16'h0000));
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("arst_no_done", {29'd0, d1, d2, d4}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
